// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: round-robin owner select for a shared mux/demux path.
// Optional forced release after MAX_HOLD cycles: define HOLD_TIMEOUT_EN.
module rr_sel_arbiter #(
  parameter int SEL_BITS = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2**SEL_BITS-1:0] req,
  input  logic                   done,
  output logic [SEL_BITS-1:0]    sel,
  output logic [2**SEL_BITS-1:0] grant,
  output logic                   valid,
  output logic                   timeout
);

  localparam int N = 2**SEL_BITS;

  if (SEL_BITS < 1 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_sel_arbiter: SEL_BITS and MAX_HOLD must be >= 1");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state;
  logic [SEL_BITS-1:0] last;
  logic [SEL_BITS-1:0] win;
  logic [SEL_BITS-1:0] cand;
  logic                found;
  logic                rel;

  // Scan upward from last+1; the add wraps naturally since N is 2**SEL_BITS.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last + SEL_BITS'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign rel = done | ~req[sel];

`ifdef HOLD_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;

  logic [HW-1:0] hold_cnt;
  logic          hit;

  assign hit = hold_cnt >= HW'(MAX_HOLD - 1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      valid <= 1'b0;
      last  <= SEL_BITS'(N - 1);
`ifdef HOLD_TIMEOUT_EN
      timeout  <= 1'b0;
      hold_cnt <= '0;
`endif
    end else begin
`ifdef HOLD_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= N'(1) << win;
            sel   <= win;
            valid <= 1'b1;
            last  <= win;
            state <= GRANT;
`ifdef HOLD_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (rel) begin
            grant <= '0;
            valid <= 1'b0;
            state <= IDLE;
`ifdef HOLD_TIMEOUT_EN
          end else if (hit) begin
            grant   <= '0;
            valid   <= 1'b0;
            timeout <= 1'b1;
            state   <= IDLE;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
